// File: rtl/ej32_fetch.sv
// Instruction-byte prefetch unit for the EJ32 core: fetches bytes from the
// memory bus into a small FIFO and presents the head byte to the decoder.
module ej32_fetch #(
  parameter int ASZ = 17,
  parameter int QD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ASZ-1:0]       br_p_i,
  input  logic                 br_psel_i,
  output logic                 mem_req_o,
  output logic [ASZ-1:0]       mem_a_o,
  input  logic                 mem_gnt_i,
  input  logic [7:0]           mem_d_i,
  output logic [7:0]           op_o,
  output logic                 op_v_o,
  input  logic                 op_rdy_i,
  output logic [ASZ-1:0]       p_o,
  output logic [$clog2(QD):0]  q_cnt_o
);

  localparam int AW = $clog2(QD);
  localparam logic [AW+1:0]  QD_L  = (AW+2)'(QD);
  localparam logic [ASZ-1:0] ONE_A = ASZ'(1);
  localparam logic [AW-1:0]  ONE_P = AW'(1);
  localparam logic [AW:0]    ONE_C = (AW+1)'(1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [ASZ-1:0] f_a_q, f_a_d;
  logic [ASZ-1:0] p_q, p_d;
  logic [7:0]     op_q, op_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic           infl_q, infl_d;
  logic [7:0]     buf_q [QD];

  logic           room_s;
  logic           req_s;
  logic           grant_s;
  logic           push_s;
  logic           pop_s;

  // Request and queue handshake qualifiers; a redirect suppresses all of them.
  always_comb begin
    room_s  = ({1'b0, cnt_q} + {{(AW+1){1'b0}}, infl_q}) < QD_L;
    req_s   = rst_n & room_s & ~br_psel_i;
    grant_s = req_s & mem_gnt_i;
    push_s  = infl_q & (state_q == RUN) & ~br_psel_i;
    pop_s   = (cnt_q != '0) & op_rdy_i & ~br_psel_i;
    infl_d  = grant_s;
  end

  // Next-state logic: RUN while the stream is valid, FLUSH for the cycle after a redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (br_psel_i) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (br_psel_i) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pointer, count and head-byte next-state; redirect overrides push and pop.
  always_comb begin
    f_a_d = f_a_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    op_d  = op_q;
    if (br_psel_i) begin
      f_a_d = br_p_i;
      p_d   = br_p_i;
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      if (grant_s) begin
        f_a_d = f_a_q + ONE_A;
      end else begin
        f_a_d = f_a_q;
      end
      if (push_s) begin
        wr_d = wr_q + ONE_P;
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + ONE_P;
        p_d  = p_q + ONE_A;
      end else begin
        rd_d = rd_q;
        p_d  = p_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + ONE_C;
        2'b01:   cnt_d = cnt_q - ONE_C;
        default: cnt_d = cnt_q;
      endcase
    end
    // The arriving byte lands in the head slot only when it is the sole survivor.
    if (cnt_d != '0) begin
      if (push_s && (wr_q == rd_d)) begin
        op_d = mem_d_i;
      end else begin
        op_d = buf_q[rd_d];
      end
    end else begin
      op_d = op_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      f_a_q   <= '0;
      p_q     <= '0;
      op_q    <= 8'h00;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_a_q   <= f_a_d;
      p_q     <= p_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      infl_q  <= infl_d;
    end
  end

  // Queue storage; contents beyond the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_q[wr_q] <= mem_d_i;
    end
  end

  assign mem_req_o = req_s;
  assign mem_a_o   = f_a_q;
  assign op_o      = op_q;
  assign op_v_o    = (cnt_q != '0);
  assign p_o       = p_q;
  assign q_cnt_o   = cnt_q;

endmodule
